// File: rtl/gesture_frame_unpacker.sv
// Gesture frame unpacker: recovers label/distance from a packed HDC frame
// and streams a header word plus the sign-restored samples.
module gesture_frame_unpacker #(
  parameter int LABEL_WIDTH     = 5,
  parameter int DISTANCE_WIDTH  = 10,
  parameter int WORDS_PER_FRAME = 64
) (
  input  logic                          Clk_CI,
  input  logic                          Reset_RI,
  input  logic                          ValidIn_SI,
  output logic                          ReadyOut_SO,
  input  logic [16*WORDS_PER_FRAME-1:0] FrameIn_DI,
  output logic                          ValidOut_SO,
  input  logic                          ReadyIn_SI,
  output logic [15:0]                   WordOut_DO,
  output logic                          LastOut_SO,
  output logic [LABEL_WIDTH-1:0]        LabelOut_DO,
  output logic [DISTANCE_WIDTH-1:0]     DistanceOut_DO,
  output logic                          ResultChange_SO,
  output logic [15:0]                   FrameCnt_DO,
  output logic [7:0]                    DropCnt_DO
);

  localparam int FW   = 16 * WORDS_PER_FRAME;
  localparam int EMB  = LABEL_WIDTH + DISTANCE_WIDTH;
  localparam int IDXW = $clog2(WORDS_PER_FRAME);

  typedef enum logic [1:0] {IDLE, HEADER, BODY} state_t;

  state_t                    state_q;
  logic [FW-1:0]             frame_q;
  logic [6:0]                idx_q;
  logic [LABEL_WIDTH-1:0]    label_q;
  logic [DISTANCE_WIDTH-1:0] dist_q;
  logic [15:0]               word_q;
  logic                      valid_q;
  logic                      last_q;
  logic                      change_q;
  logic [15:0]               cnt_q;
  logic [7:0]                drop_q;

  logic [LABEL_WIDTH-1:0]    label_new;
  logic [DISTANCE_WIDTH-1:0] dist_new;
  logic [IDXW-1:0]           sel_idx;
  logic [15:0]               raw_word;
  logic [15:0]               out_word;
  logic                      hs;

  always_comb begin
    label_new = '0;
    dist_new  = '0;
    for (int i = 0; i < LABEL_WIDTH; i++)
      label_new[i] = FrameIn_DI[16*i+15];
    for (int i = 0; i < DISTANCE_WIDTH; i++)
      dist_new[i] = FrameIn_DI[16*(i+LABEL_WIDTH)+15];
  end

  // Word to present after the current handshake
  always_comb begin
    sel_idx = '0;
    if (state_q == BODY)
      sel_idx = IDXW'(idx_q + 7'd1);
    raw_word = frame_q[16*int'(sel_idx) +: 16];
    out_word = raw_word;
    if (sel_idx < IDXW'(EMB))
      out_word[15] = raw_word[14];
  end

  assign hs = valid_q && ReadyIn_SI;

  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      state_q  <= IDLE;
      frame_q  <= '0;
      idx_q    <= '0;
      label_q  <= '0;
      dist_q   <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      change_q <= 1'b0;
      cnt_q    <= '0;
      drop_q   <= '0;
    end else begin
      change_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (ValidIn_SI) begin
            frame_q  <= FrameIn_DI;
            label_q  <= label_new;
            dist_q   <= dist_new;
            cnt_q    <= cnt_q + 16'd1;
            change_q <= (label_new != label_q);
            word_q   <= {1'b1, label_new, dist_new};
            valid_q  <= 1'b1;
            last_q   <= 1'b0;
            state_q  <= HEADER;
          end
        end
        HEADER: begin
          if (hs) begin
            idx_q   <= '0;
            word_q  <= out_word;
            last_q  <= (sel_idx == IDXW'(WORDS_PER_FRAME-1));
            state_q <= BODY;
          end
        end
        BODY: begin
          if (hs) begin
            if (idx_q == 7'(WORDS_PER_FRAME-1)) begin
              idx_q   <= '0;
              word_q  <= '0;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              idx_q  <= idx_q + 7'd1;
              word_q <= out_word;
              last_q <= (sel_idx == IDXW'(WORDS_PER_FRAME-1));
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      if (ValidIn_SI && state_q != IDLE && drop_q != 8'hFF)
        drop_q <= drop_q + 8'd1;
    end
  end

  assign ReadyOut_SO     = (state_q == IDLE) && !Reset_RI;
  assign ValidOut_SO     = valid_q;
  assign WordOut_DO      = word_q;
  assign LastOut_SO      = last_q;
  assign LabelOut_DO     = label_q;
  assign DistanceOut_DO  = dist_q;
  assign ResultChange_SO = change_q;
  assign FrameCnt_DO     = cnt_q;
  assign DropCnt_DO      = drop_q;

endmodule
